// File: rtl/column_loader_harness_pkg.sv
// Shared helpers for the column loader harness: column geometry and fixed constants.
// Column c of an N x N multiplier holds h(c)=min(c+1, 2N-1-c) partial-product bits.
package column_pkg;

    localparam logic [63:0] LFSR_TAPS        = 64'hD800_0000_0000_0000;
    localparam logic [31:0] SIG_POLY_DEFAULT = 32'h04C1_1DB7;

    // Height of column c for operand width n.
    function automatic int unsigned col_height(input int unsigned n, input int unsigned c);
        int unsigned rising;
        int unsigned falling;
        rising  = c + 1;
        falling = 2 * n - 1 - c;
        return (rising < falling) ? rising : falling;
    endfunction

    // Bit offset of column c inside the flattened column vector.
    function automatic int unsigned col_offset(input int unsigned n, input int unsigned c);
        int unsigned acc;
        acc = 0;
        for (int unsigned i = 0; i < c; i++) begin
            acc += col_height(n, i);
        end
        return acc;
    endfunction

    // Total partial-product bits across all columns.
    function automatic int unsigned total_bits(input int unsigned n);
        return n * n;
    endfunction

endpackage

// File: rtl/column_loader_harness_if.sv
// Harness bus: host controls and serial feed, compressor drive/return, capture and signature.
//  master : host/generated top (drives controls, src_in, dst_in)
//  slave  : column_loader_harness
interface column_loader_harness_if #(
    parameter int unsigned N     = 15,
    parameter int unsigned DST_W = 2 * N + 1,
    parameter int unsigned SIG_W = 32
);
    localparam int unsigned COLS  = 2 * N - 1;
    localparam int unsigned TOTAL = column_pkg::total_bits(N);

    logic             clear;
    logic             shift_en;
    logic             lfsr_mode;
    logic             sig_en;
    logic [COLS-1:0]  src_in;
    logic [TOTAL-1:0] cols_flat;
    logic [DST_W-1:0] dst_in;
    logic             full;
    logic             dst_valid;
    logic [DST_W-1:0] dst_q;
    logic [SIG_W-1:0] signature;

    modport master (
        output clear, shift_en, lfsr_mode, sig_en, src_in, dst_in,
        input  cols_flat, full, dst_valid, dst_q, signature
    );

    modport slave (
        input  clear, shift_en, lfsr_mode, sig_en, src_in, dst_in,
        output cols_flat, full, dst_valid, dst_q, signature
    );

endinterface

// File: rtl/column_loader_harness_shreg.sv
// One column shift register of height H; newest bit at LSB.
//  clk, rst   : clock, synchronous active-high reset
//  clear_i    : synchronous restart to zero, wins over shift_i
//  shift_i    : shift one position this cycle
//  bit_i      : serial bit entering at LSB
//  col_o      : registered column contents
module column_shreg #(
    parameter int unsigned H = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         shift_i,
    input  logic         bit_i,
    output logic [H-1:0] col_o
);

    logic [H-1:0] col_q;
    logic [H-1:0] col_d;

    // Truncating the concatenation drops the oldest bit; for H=1 it is a plain load.
    always_comb begin
        col_d = col_q;
        if (shift_i) begin
            col_d = H'({col_q, bit_i});
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign col_o = col_q;

endmodule

// File: rtl/column_loader_harness.sv
// Stimulus/capture harness for an N x N column compressor.
// Loads 2N-1 triangular column registers from pins or a 64-bit LFSR, exposes them flattened,
// pipelines the compressor result with a "columns full" tag and folds valid results into a MISR.
//  clk, rst : clock, synchronous active-high reset (LFSR reseeded only by rst)
//  bus      : column_loader_harness_if slave modport
module column_loader_harness
    import column_pkg::*;
#(
    parameter int unsigned      N          = 15,
    parameter int unsigned      DST_W      = 2 * N + 1,
    parameter int unsigned      CAP_STAGES = 1,
    parameter int unsigned      SIG_W      = 32,
    parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(SIG_POLY_DEFAULT),
    parameter logic [63:0]      LFSR_SEED  = 64'h0000_0000_0000_0001
) (
    input  logic clk,
    input  logic rst,
    column_loader_harness_if.slave bus
);

    localparam int unsigned COLS  = 2 * N - 1;
    localparam int unsigned TOTAL = total_bits(N);
    localparam int unsigned DEPTH = N;
    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [63:0]      lfsr_q;
    logic [63:0]      lfsr_d;
    logic [CNT_W-1:0] fill_cnt_q;
    logic [CNT_W-1:0] fill_cnt_d;
    logic             full_q;
    logic [DST_W:0]   cap_q [CAP_STAGES];
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [COLS-1:0]  bits_c;
    logic [TOTAL-1:0] cols_flat_c;
    logic             valid_c;
    logic [DST_W-1:0] dst_c;

    // Column storage, one register per multiplier column.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int unsigned H   = col_height(N, c);
        localparam int unsigned OFF = col_offset(N, c);
        column_shreg #(.H(H)) u_col (
            .clk     (clk),
            .rst     (rst),
            .clear_i (bus.clear),
            .shift_i (bus.shift_en),
            .bit_i   (bits_c[c]),
            .col_o   (cols_flat_c[OFF +: H])
        );
    end

    assign {valid_c, dst_c} = cap_q[CAP_STAGES-1];

    // Serial source select, LFSR step, fill counter and MISR next state.
    always_comb begin
        bits_c     = bus.lfsr_mode ? lfsr_q[COLS-1:0] : bus.src_in;
        lfsr_d     = lfsr_q;
        fill_cnt_d = fill_cnt_q;
        sig_d      = sig_q;
        // Columns consume the pre-step LFSR state; a clear cycle leaves the LFSR alone.
        if (bus.shift_en && bus.lfsr_mode && !bus.clear) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 64'h0);
        end
        if (bus.shift_en && (fill_cnt_q != CNT_W'(DEPTH))) begin
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
        if (valid_c && bus.sig_en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ SIG_W'(dst_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Fill tracking, tagged capture pipe and signature; clear restarts all of it.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            fill_cnt_q <= '0;
            full_q     <= 1'b0;
            sig_q      <= '0;
            for (int k = 0; k < CAP_STAGES; k++) begin
                cap_q[k] <= '0;
            end
        end else begin
            fill_cnt_q <= fill_cnt_d;
            full_q     <= (fill_cnt_d == CNT_W'(DEPTH));
            sig_q      <= sig_d;
            cap_q[0]   <= {full_q, bus.dst_in};
            for (int k = 1; k < CAP_STAGES; k++) begin
                cap_q[k] <= cap_q[k-1];
            end
        end
    end

    assign bus.cols_flat = cols_flat_c;
    assign bus.full      = full_q;
    assign bus.dst_valid = valid_c;
    assign bus.dst_q     = dst_c;
    assign bus.signature = sig_q;

endmodule

// File: tb/tb_column_loader_harness.sv
// Directed bench for column_loader_harness at N=3 (columns 1,2,3,2,1; offsets 0,1,3,6,8).
module tb_column_loader_harness;

    localparam int unsigned N     = 3;
    localparam int unsigned DST_W = 2 * N + 1;
    localparam int unsigned SIG_W = 32;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    column_loader_harness_if #(.N(N), .DST_W(DST_W), .SIG_W(SIG_W)) bus ();

    column_loader_harness #(
        .N          (N),
        .DST_W      (DST_W),
        .CAP_STAGES (1),
        .SIG_W      (SIG_W),
        .SIG_POLY   (32'h04C1_1DB7),
        .LFSR_SEED  (64'h0000_0000_0000_0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.shift_en  = 1'b0;
        bus.lfsr_mode = 1'b0;
        bus.sig_en    = 1'b0;
        bus.src_in    = '0;
        bus.dst_in    = '0;

        // Reset state
        step();
        rst = 1'b0;
        check("rst_cols", 64'(bus.cols_flat), 64'h0);
        check("rst_full", 64'(bus.full), 64'h0);
        check("rst_valid", 64'(bus.dst_valid), 64'h0);
        check("rst_sig", 64'(bus.signature), 64'h0);
        check("rst_lfsr", dut.lfsr_q, 64'h1);

        // dst_q follows dst_in one cycle later even while untagged
        bus.dst_in = 7'h55;
        step();
        check("pipe_dst_untagged", 64'(bus.dst_q), 64'h55);
        check("pipe_valid_untagged", 64'(bus.dst_valid), 64'h0);
        bus.dst_in = '0;

        // Fill with all ones
        bus.src_in   = 5'b11111;
        bus.shift_en = 1'b1;
        step();
        step();
        check("fill2_full", 64'(bus.full), 64'h0);
        step();
        check("fill3_full", 64'(bus.full), 64'h1);
        check("fill3_cols", 64'(bus.cols_flat), 64'h1FF);
        check("fill3_valid", 64'(bus.dst_valid), 64'h0);
        bus.shift_en = 1'b0;
        step();
        check("valid_after_full", 64'(bus.dst_valid), 64'h1);
        check("valid_dst", 64'(bus.dst_q), 64'h0);

        // Column 0 single bit flushed, then a marker walked through column 2
        bus.shift_en = 1'b1;
        bus.src_in   = 5'b00001;
        step();
        bus.src_in = 5'b00000;
        step();
        step();
        check("col0_flushed", 64'(bus.cols_flat), 64'h000);
        check("full_saturated", 64'(bus.full), 64'h1);
        bus.src_in = 5'b00100;
        step();
        bus.src_in = 5'b00000;
        step();
        step();
        check("col2_marker", 64'(bus.cols_flat), 64'h020);
        bus.shift_en = 1'b0;

        // MISR fold of dst=1 over two valid cycles, then hold
        bus.dst_in = 7'h01;
        step();
        check("misr_dst_ready", 64'(bus.dst_q), 64'h1);
        check("misr_idle", 64'(bus.signature), 64'h0);
        bus.sig_en = 1'b1;
        step();
        check("misr_1", 64'(bus.signature), 64'h1);
        step();
        check("misr_2", 64'(bus.signature), 64'h3);
        bus.sig_en = 1'b0;
        step();
        check("misr_hold", 64'(bus.signature), 64'h3);
        check("cols_stable_no_shift", 64'(bus.cols_flat), 64'h020);

        // Clear restarts everything except the LFSR
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clr_full", 64'(bus.full), 64'h0);
        check("clr_cols", 64'(bus.cols_flat), 64'h0);
        check("clr_valid", 64'(bus.dst_valid), 64'h0);
        check("clr_sig", 64'(bus.signature), 64'h0);

        // Two shifts, then clear together with shift_en
        bus.src_in   = 5'b11111;
        bus.shift_en = 1'b1;
        step();
        step();
        check("partial_cols", 64'(bus.cols_flat), 64'h1DF);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clr_shift_cnt", 64'(dut.fill_cnt_q), 64'h0);
        check("clr_shift_cols", 64'(bus.cols_flat), 64'h0);
        check("clr_shift_full", 64'(bus.full), 64'h0);
        step();
        step();
        check("refill2_full", 64'(bus.full), 64'h0);
        step();
        check("refill3_full", 64'(bus.full), 64'h1);
        check("refill3_cols", 64'(bus.cols_flat), 64'h1FF);
        bus.shift_en = 1'b0;

        // LFSR-fed shifts from the seed; src_in left at all ones must be ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.lfsr_mode = 1'b1;
        bus.shift_en  = 1'b1;
        step();
        bus.shift_en = 1'b0;
        check("lfsr1_cols", 64'(bus.cols_flat), 64'h001);
        check("lfsr1_state", dut.lfsr_q, 64'hD800_0000_0000_0000);
        bus.shift_en = 1'b1;
        step();
        bus.shift_en = 1'b0;
        check("lfsr2_cols", 64'(bus.cols_flat), 64'h000);
        check("lfsr2_state", dut.lfsr_q, 64'h6C00_0000_0000_0000);
        check("lfsr2_full", 64'(bus.full), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
